// File: rtl/hit_judge_if.sv
// rtl/hit_judge_if.sv - player/note/score bundle between the game fabric and hit_judge
//
// Signals:
//   clear        synchronous game restart
//   note_valid   1-cycle pulse, note reaches target line
//   note_lanes   lane mask of that note (L,D,U,R)
//   btn          synchronised button levels
//   score_out    running score
//   combo        consecutive-hit count
//   mult         current multiplier
//   judge_valid  1-cycle pulse, note graded
//   judge_grade  00 none, 01 PERFECT, 10 GOOD, 11 MISS
//   note_drop    1-cycle pulse, note discarded while busy
// Modports: master drives the inputs of hit_judge, slave is hit_judge itself.
interface hit_judge_if;
    logic        clear;
    logic        note_valid;
    logic [3:0]  note_lanes;
    logic [3:0]  btn;
    logic [31:0] score_out;
    logic [15:0] combo;
    logic [2:0]  mult;
    logic        judge_valid;
    logic [1:0]  judge_grade;
    logic        note_drop;

    modport master (
        output clear, note_valid, note_lanes, btn,
        input  score_out, combo, mult, judge_valid, judge_grade, note_drop
    );

    modport slave (
        input  clear, note_valid, note_lanes, btn,
        output score_out, combo, mult, judge_valid, judge_grade, note_drop
    );
endinterface

// File: rtl/hit_judge.sv
// rtl/hit_judge.sv - grades button presses against arriving notes, keeps combo/multiplier/score
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    hit_judge_if.slave: clear, note_valid, note_lanes, btn in;
//          score_out, combo, mult, judge_valid, judge_grade, note_drop out
module hit_judge #(
    parameter int unsigned WINDOW      = 16,
    parameter int unsigned PERFECT_WIN = 4,
    parameter int unsigned PERFECT_PTS = 100,
    parameter int unsigned GOOD_PTS    = 50,
    parameter int unsigned COMBO_STEP  = 10,
    parameter int unsigned MAX_MULT    = 4
) (
    input logic        clk,
    input logic        reset,
    hit_judge_if.slave bus
);
    localparam int TW = $clog2(WINDOW);
    localparam int SW = $clog2(COMBO_STEP + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OPEN  = 2'd1;
    localparam logic [1:0] S_JUDGE = 2'd2;

    localparam logic [1:0] G_NONE    = 2'b00;
    localparam logic [1:0] G_PERFECT = 2'b01;
    localparam logic [1:0] G_GOOD    = 2'b10;
    localparam logic [1:0] G_MISS    = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [3:0]    lanes_q, lanes_d;
    logic [3:0]    acc_q, acc_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    grade_q, grade_d;
    logic [3:0]    btn_q, btn_d;
    logic [31:0]   score_q, score_d;
    logic [15:0]   combo_q, combo_d;
    logic [2:0]    mult_q, mult_d;
    logic [SW-1:0] step_q, step_d;
    logic          judge_valid_q, judge_valid_d;
    logic [1:0]    judge_grade_q, judge_grade_d;
    logic          note_drop_q, note_drop_d;

    logic [3:0]    press_rise;
    logic [3:0]    acc_next;
    logic [31:0]   pts;
    logic [34:0]   product;
    logic [35:0]   sum;
    logic [SW-1:0] step_inc;

    always_comb begin
        press_rise = bus.btn & ~btn_q;
        // Chord presses accumulate across the window; a chord is complete
        // once every latched lane has seen a rising edge.
        acc_next   = acc_q | press_rise;
        pts        = (grade_q == G_PERFECT) ? PERFECT_PTS : GOOD_PTS;
        // Product is at most 32+3 bits; the extra sum bits detect overflow.
        product    = 35'(pts) * 35'(mult_q);
        sum        = 36'(score_q) + 36'(product);
        step_inc   = step_q + SW'(1);

        state_d       = state_q;
        lanes_d       = lanes_q;
        acc_d         = acc_q;
        timer_d       = timer_q;
        grade_d       = grade_q;
        btn_d         = bus.btn;
        score_d       = score_q;
        combo_d       = combo_q;
        mult_d        = mult_q;
        step_d        = step_q;
        judge_valid_d = 1'b0;
        judge_grade_d = judge_grade_q;
        note_drop_d   = bus.note_valid && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // Presses during the arrival cycle are ignored; only lanes latch.
                if (bus.note_valid && (bus.note_lanes != 4'd0)) begin
                    lanes_d = bus.note_lanes;
                    acc_d   = 4'd0;
                    timer_d = '0;
                    state_d = S_OPEN;
                end
            end
            S_OPEN: begin
                timer_d = timer_q + TW'(1);
                if ((press_rise != 4'd0) && ((press_rise & ~lanes_q) != 4'd0)) begin
                    grade_d = G_MISS;
                    state_d = S_JUDGE;
                end else if ((press_rise != 4'd0) && ((acc_next & lanes_q) == lanes_q)) begin
                    grade_d = (timer_q < TW'(PERFECT_WIN)) ? G_PERFECT : G_GOOD;
                    state_d = S_JUDGE;
                end else begin
                    acc_d = acc_next;
                    if (timer_q == TW'(WINDOW - 1)) begin
                        grade_d = G_MISS;
                        state_d = S_JUDGE;
                    end
                end
            end
            S_JUDGE: begin
                state_d       = S_IDLE;
                judge_valid_d = 1'b1;
                judge_grade_d = grade_q;
                if (grade_q == G_MISS) begin
                    combo_d = 16'd0;
                    step_d  = '0;
                    mult_d  = 3'd1;
                end else begin
                    // Score uses the multiplier in force before this hit.
                    score_d = (|sum[35:32]) ? 32'hFFFF_FFFF : sum[31:0];
                    combo_d = (combo_q == 16'hFFFF) ? combo_q : combo_q + 16'd1;
                    if (step_inc == SW'(COMBO_STEP)) begin
                        step_d = '0;
                        if (mult_q < 3'(MAX_MULT)) begin
                            mult_d = mult_q + 3'd1;
                        end
                    end else begin
                        step_d = step_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A restart overrides every event in the same cycle.
        if (bus.clear) begin
            state_d       = S_IDLE;
            lanes_d       = 4'd0;
            acc_d         = 4'd0;
            timer_d       = '0;
            grade_d       = G_NONE;
            btn_d         = 4'd0;
            score_d       = 32'd0;
            combo_d       = 16'd0;
            mult_d        = 3'd1;
            step_d        = '0;
            judge_valid_d = 1'b0;
            judge_grade_d = G_NONE;
            note_drop_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            lanes_q       <= 4'd0;
            acc_q         <= 4'd0;
            timer_q       <= '0;
            grade_q       <= G_NONE;
            btn_q         <= 4'd0;
            score_q       <= 32'd0;
            combo_q       <= 16'd0;
            mult_q        <= 3'd1;
            step_q        <= '0;
            judge_valid_q <= 1'b0;
            judge_grade_q <= G_NONE;
            note_drop_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lanes_q       <= lanes_d;
            acc_q         <= acc_d;
            timer_q       <= timer_d;
            grade_q       <= grade_d;
            btn_q         <= btn_d;
            score_q       <= score_d;
            combo_q       <= combo_d;
            mult_q        <= mult_d;
            step_q        <= step_d;
            judge_valid_q <= judge_valid_d;
            judge_grade_q <= judge_grade_d;
            note_drop_q   <= note_drop_d;
        end
    end

    assign bus.score_out   = score_q;
    assign bus.combo       = combo_q;
    assign bus.mult        = mult_q;
    assign bus.judge_valid = judge_valid_q;
    assign bus.judge_grade = judge_grade_q;
    assign bus.note_drop   = note_drop_q;
endmodule

// File: tb/tb_hit_judge.sv
// tb/tb_hit_judge.sv - self-checking bench for hit_judge
module tb_hit_judge;
    localparam int WINDOW      = 16;
    localparam int PERFECT_WIN = 4;
    localparam int PERFECT_PTS = 100;
    localparam int GOOD_PTS    = 50;
    localparam int COMBO_STEP  = 10;
    localparam int MAX_MULT    = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    hit_judge_if dif ();
    hit_judge_if bif ();

    assign bif.clear      = dif.clear;
    assign bif.note_valid = dif.note_valid;
    assign bif.note_lanes = dif.note_lanes;
    assign bif.btn        = dif.btn;

    hit_judge u_dut (.clk(clk), .reset(rst_n), .bus(dif));
    hit_judge #(.PERFECT_PTS(32'h7FFF_FFFF)) u_big (.clk(clk), .reset(rst_n), .bus(bif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: notes are cycle-stamped; grade timing derives from
    // the stamp, multiplier derives from the unbroken hit streak.
    int         cyc;
    bit         m_active, m_decided;
    int         m_arrive;
    logic [3:0] m_lanes, m_acc, m_prev_btn;
    logic [1:0] m_grade;
    longint     m_score;
    int         m_streak;
    bit         e_jv, e_drop;
    logic [1:0] e_grade;

    function automatic int m_mult();
        int m;
        m = 1 + m_streak / COMBO_STEP;
        return (m > MAX_MULT) ? MAX_MULT : m;
    endfunction

    function automatic int m_combo();
        return (m_streak > 65535) ? 65535 : m_streak;
    endfunction

    function automatic void model_reset();
        m_active = 0; m_decided = 0; m_arrive = 0;
        m_lanes = 0; m_acc = 0; m_prev_btn = 0; m_grade = 0;
        m_score = 0; m_streak = 0;
        e_jv = 0; e_drop = 0; e_grade = 0;
    endfunction

    function automatic void model_apply(input logic [1:0] g);
        longint p;
        if (g == 2'b11) begin
            m_streak = 0;
        end else begin
            p = (g == 2'b01) ? PERFECT_PTS : GOOD_PTS;
            m_score = m_score + p * m_mult();
            if (m_score > 64'hFFFF_FFFF) m_score = 64'hFFFF_FFFF;
            m_streak++;
        end
    endfunction

    function automatic void model_edge(input bit clr, input bit nv, input logic [3:0] ln, input logic [3:0] bt);
        logic [3:0] rise;
        int t;
        cyc++;
        if (clr) begin
            model_reset();
            return;
        end
        rise = bt & ~m_prev_btn;
        m_prev_btn = bt;
        e_jv = 0;
        e_drop = 0;
        if (m_active) begin
            if (nv) e_drop = 1;
            if (m_decided) begin
                model_apply(m_grade);
                e_jv = 1;
                e_grade = m_grade;
                m_active = 0;
            end else begin
                t = cyc - m_arrive - 1;
                if (rise != 0) begin
                    if ((rise & ~m_lanes) != 0) begin
                        m_decided = 1; m_grade = 2'b11;
                    end else begin
                        m_acc = m_acc | rise;
                        if (m_acc == m_lanes) begin
                            m_decided = 1;
                            m_grade = (t < PERFECT_WIN) ? 2'b01 : 2'b10;
                        end
                    end
                end
                if (!m_decided && t == WINDOW - 1) begin
                    m_decided = 1; m_grade = 2'b11;
                end
            end
        end else if (nv && ln != 0) begin
            m_active = 1; m_decided = 0; m_arrive = cyc; m_lanes = ln; m_acc = 0;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        chk("score", dif.score_out, m_score[31:0]);
        chk("combo", 32'(dif.combo), 32'(m_combo()));
        chk("mult", 32'(dif.mult), 32'(m_mult()));
        chk("judge_valid", 32'(dif.judge_valid), 32'(e_jv));
        chk("judge_grade", 32'(dif.judge_grade), 32'(e_grade));
        chk("note_drop", 32'(dif.note_drop), 32'(e_drop));
    endtask

    task automatic step(input bit clr, input bit nv, input logic [3:0] ln, input logic [3:0] bt);
        @(negedge clk);
        dif.clear = clr; dif.note_valid = nv; dif.note_lanes = ln; dif.btn = bt;
        @(posedge clk);
        model_edge(clr, nv, ln, bt);
        #1;
        check_model();
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, "_score"}, dif.score_out, 32'd0);
        chk({nm, "_combo"}, 32'(dif.combo), 32'd0);
        chk({nm, "_mult"}, 32'(dif.mult), 32'd1);
        chk({nm, "_jv"}, 32'(dif.judge_valid), 32'd0);
        chk({nm, "_grade"}, 32'(dif.judge_grade), 32'd0);
        chk({nm, "_drop"}, 32'(dif.note_drop), 32'd0);
    endtask

    typedef struct {
        bit          clr;
        bit          nv;
        logic [3:0]  lanes;
        logic [3:0]  btn;
        bit          jv;
        logic [1:0]  grade;
        logic [31:0] score;
        logic [15:0] combo;
        logic [2:0]  mult;
        bit          drop;
    } vec_t;

    vec_t tbl [20];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] bt;
        logic [3:0] last_ln;

        n_tests = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0;
        dif.clear = 0; dif.note_valid = 0; dif.note_lanes = 0; dif.btn = 0;
        model_reset();

        // PERFECT at timer 2, ignored empty note and idle press, wrong-lane MISS,
        // two-cycle chord, drop during JUDGE, note accepted as judge_valid rises.
        tbl[0]  = '{0, 1, 4'b0001, 4'b0000, 0, 2'd0, 32'd0,   16'd0, 3'd1, 0};
        tbl[1]  = '{0, 0, 4'b0000, 4'b0000, 0, 2'd0, 32'd0,   16'd0, 3'd1, 0};
        tbl[2]  = '{0, 0, 4'b0000, 4'b0000, 0, 2'd0, 32'd0,   16'd0, 3'd1, 0};
        tbl[3]  = '{0, 0, 4'b0000, 4'b0001, 0, 2'd0, 32'd0,   16'd0, 3'd1, 0};
        tbl[4]  = '{0, 0, 4'b0000, 4'b0001, 1, 2'd1, 32'd100, 16'd1, 3'd1, 0};
        tbl[5]  = '{0, 0, 4'b0000, 4'b0000, 0, 2'd1, 32'd100, 16'd1, 3'd1, 0};
        tbl[6]  = '{0, 1, 4'b0000, 4'b0000, 0, 2'd1, 32'd100, 16'd1, 3'd1, 0};
        tbl[7]  = '{0, 0, 4'b0000, 4'b0001, 0, 2'd1, 32'd100, 16'd1, 3'd1, 0};
        tbl[8]  = '{0, 1, 4'b0001, 4'b0000, 0, 2'd1, 32'd100, 16'd1, 3'd1, 0};
        tbl[9]  = '{0, 0, 4'b0000, 4'b0010, 0, 2'd1, 32'd100, 16'd1, 3'd1, 0};
        tbl[10] = '{0, 0, 4'b0000, 4'b0000, 1, 2'd3, 32'd100, 16'd0, 3'd1, 0};
        tbl[11] = '{0, 0, 4'b0000, 4'b0000, 0, 2'd3, 32'd100, 16'd0, 3'd1, 0};
        tbl[12] = '{0, 1, 4'b0011, 4'b0000, 0, 2'd3, 32'd100, 16'd0, 3'd1, 0};
        tbl[13] = '{0, 0, 4'b0000, 4'b0001, 0, 2'd3, 32'd100, 16'd0, 3'd1, 0};
        tbl[14] = '{0, 0, 4'b0000, 4'b0011, 0, 2'd3, 32'd100, 16'd0, 3'd1, 0};
        tbl[15] = '{0, 1, 4'b1000, 4'b0000, 1, 2'd1, 32'd200, 16'd1, 3'd1, 1};
        tbl[16] = '{0, 1, 4'b0100, 4'b0000, 0, 2'd1, 32'd200, 16'd1, 3'd1, 0};
        tbl[17] = '{0, 0, 4'b0000, 4'b0100, 0, 2'd1, 32'd200, 16'd1, 3'd1, 0};
        tbl[18] = '{0, 0, 4'b0000, 4'b0000, 1, 2'd1, 32'd300, 16'd2, 3'd1, 0};
        tbl[19] = '{0, 0, 4'b0000, 4'b0000, 0, 2'd1, 32'd300, 16'd2, 3'd1, 0};

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].clr, tbl[i].nv, tbl[i].lanes, tbl[i].btn);
            chk($sformatf("tbl%0d_jv", i), 32'(dif.judge_valid), 32'(tbl[i].jv));
            chk($sformatf("tbl%0d_grade", i), 32'(dif.judge_grade), 32'(tbl[i].grade));
            chk($sformatf("tbl%0d_score", i), dif.score_out, tbl[i].score);
            chk($sformatf("tbl%0d_combo", i), 32'(dif.combo), 32'(tbl[i].combo));
            chk($sformatf("tbl%0d_mult", i), 32'(dif.mult), 32'(tbl[i].mult));
            chk($sformatf("tbl%0d_drop", i), 32'(dif.note_drop), 32'(tbl[i].drop));
        end

        // Timeout MISS: timer reaches 15, judge visible two cycles later.
        step(0, 1, 4'b0010, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 4'b0000, 4'b0000);
            chk("timeout_quiet_jv", 32'(dif.judge_valid), 32'd0);
        end
        step(0, 0, 4'b0000, 4'b0000);
        chk("timeout_jv", 32'(dif.judge_valid), 32'd1);
        chk("timeout_grade", 32'(dif.judge_grade), 32'd3);
        chk("timeout_combo", 32'(dif.combo), 32'd0);
        chk("timeout_mult", 32'(dif.mult), 32'd1);

        // Clear, then ten PERFECTs raise the multiplier; the eleventh scores double.
        step(1, 1, 4'b0001, 4'b0001);
        check_reset_values("clear");
        for (int i = 0; i < 11; i++) begin
            step(0, 1, 4'b0001, 4'b0000);
            step(0, 0, 4'b0000, 4'b0001);
            step(0, 0, 4'b0000, 4'b0000);
            if (i == 9) begin
                chk("ten_score", dif.score_out, 32'd1000);
                chk("ten_mult", 32'(dif.mult), 32'd2);
                chk("ten_combo", 32'(dif.combo), 32'd10);
            end
        end
        chk("eleven_score", dif.score_out, 32'd1200);

        // Saturating score on the large-points instance.
        step(1, 0, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 4'b0001, 4'b0000);
            step(0, 0, 4'b0000, 4'b0001);
            step(0, 0, 4'b0000, 4'b0000);
            case (i)
                0: chk("sat_score0", bif.score_out, 32'h7FFF_FFFF);
                1: chk("sat_score1", bif.score_out, 32'hFFFF_FFFE);
                default: chk("sat_score2", bif.score_out, 32'hFFFF_FFFF);
            endcase
        end

        // Drop during OPEN, original note still graded (GOOD at timer 4).
        step(1, 0, 4'b0000, 4'b0000);
        step(0, 1, 4'b0001, 4'b0000);
        step(0, 1, 4'b0010, 4'b0000);
        chk("open_drop", 32'(dif.note_drop), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 4'b0000, 4'b0000);
        step(0, 0, 4'b0000, 4'b0001);
        step(0, 0, 4'b0000, 4'b0000);
        chk("good_jv", 32'(dif.judge_valid), 32'd1);
        chk("good_grade", 32'(dif.judge_grade), 32'd2);
        chk("good_score", dif.score_out, 32'd50);

        // Asynchronous reset in the middle of OPEN.
        step(0, 1, 4'b0100, 4'b0000);
        step(0, 0, 4'b0000, 4'b0000);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(0, 0, 4'b0000, 4'b0100);

        // Randomised traffic against the model.
        bt = 0;
        last_ln = 4'b0001;
        for (int i = 0; i < 3000; i++) begin
            bit c;
            bit v;
            logic [3:0] ln;
            c  = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 4) == 0);
            ln = 4'($urandom_range(0, 15));
            if (v && ln != 0) last_ln = ln;
            case ($urandom_range(0, 5))
                0: bt = 4'b0000;
                1: bt = last_ln;
                2: bt = 4'($urandom_range(0, 15));
                3: bt = bt | (last_ln & 4'($urandom_range(0, 15)));
                default: ;
            endcase
            step(c, v, ln, bt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
